// File: rtl/acc_flags_if.sv
// Request bus for acc_flags: valid/ready handshake carrying an opcode and B operand.
interface acc_flags_if;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op;
    logic [7:0] operand;

    modport master (output op_valid, output op, output operand, input op_ready);
    modport slave  (input op_valid, input op, input operand, output op_ready);
endinterface

// File: rtl/acc_flags.sv
// Accumulator + C/Z/N/V flag stage time-sharing one 8-bit ripple adder; ops that
// need a +1 carry-in take a second adder pass through a two-state FSM.

module adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum,
    output logic       cout
);
    logic carry;

    always_comb begin
        carry = 1'b0;
        sum   = '0;
        for (int i = 0; i < 8; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end
endmodule

module acc_flags (
    input  logic           clk,
    input  logic           rst_n,
    acc_flags_if.slave     bus,
    output logic [7:0]     acc,
    output logic           flag_c,
    output logic           flag_z,
    output logic           flag_n,
    output logic           flag_v,
    output logic           done
);
    typedef enum logic [2:0] {
        OP_LOAD = 3'b000,
        OP_ADD  = 3'b001,
        OP_ADC  = 3'b010,
        OP_SUB  = 3'b011,
        OP_SBC  = 3'b100,
        OP_INC  = 3'b101,
        OP_DEC  = 3'b110,
        OP_CMP  = 3'b111
    } op_t;

    typedef enum logic {IDLE, PASS2} state_t;

    state_t     state;
    logic [7:0] temp_s;
    logic       temp_c;
    logic       temp_e7;
    logic       temp_a7;
    op_t        temp_op;

    logic       accept;
    op_t        req_op;
    logic [7:0] eff_b;
    logic       cin;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic [7:0] add_s;
    logic       add_c;

    logic       commit;
    logic       go_pass2;
    op_t        cur_op;
    logic [7:0] res;
    logic       carry;
    logic       a7;
    logic       e7;
    logic       ovf;

    assign bus.op_ready = (state == IDLE);
    assign accept       = bus.op_valid && bus.op_ready;
    assign req_op       = op_t'(bus.op);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        eff_b = bus.operand;
        cin   = 1'b0;
        unique case (req_op)
            OP_LOAD: begin eff_b = bus.operand;  cin = 1'b0;   end
            OP_ADD:  begin eff_b = bus.operand;  cin = 1'b0;   end
            OP_ADC:  begin eff_b = bus.operand;  cin = flag_c; end
            OP_SUB:  begin eff_b = ~bus.operand; cin = 1'b1;   end
            OP_SBC:  begin eff_b = ~bus.operand; cin = flag_c; end
            OP_INC:  begin eff_b = 8'h01;        cin = 1'b0;   end
            OP_DEC:  begin eff_b = 8'hFF;        cin = 1'b0;   end
            OP_CMP:  begin eff_b = ~bus.operand; cin = 1'b1;   end
            default: begin eff_b = bus.operand;  cin = 1'b0;   end
        endcase
    end

    // The single adder's inputs are steered by state: pass 2 adds the carry-in to s1.
    assign add_a = (state == PASS2) ? temp_s : acc;
    assign add_b = (state == PASS2) ? 8'h01  : eff_b;

    adder8 u_adder (
        .a    (add_a),
        .b    (add_b),
        .sum  (add_s),
        .cout (add_c)
    );

    always_comb begin
        commit   = 1'b0;
        go_pass2 = 1'b0;
        cur_op   = req_op;
        res      = add_s;
        carry    = add_c;
        a7       = acc[7];
        e7       = eff_b[7];
        if (state == PASS2) begin
            commit = 1'b1;
            cur_op = temp_op;
            carry  = temp_c | add_c;
            a7     = temp_a7;
            e7     = temp_e7;
        end else if (accept) begin
            if (req_op == OP_LOAD) begin
                commit = 1'b1;
                res    = bus.operand;
            end else if (cin) begin
                go_pass2 = 1'b1;
            end else begin
                commit = 1'b1;
            end
        end
        ovf = (a7 == e7) && (res[7] != a7);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            temp_s  <= '0;
            temp_c  <= 1'b0;
            temp_e7 <= 1'b0;
            temp_a7 <= 1'b0;
            temp_op <= OP_LOAD;
            acc     <= '0;
            flag_c  <= 1'b0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            flag_v  <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= commit;
            if (go_pass2) begin
                state   <= PASS2;
                temp_s  <= add_s;
                temp_c  <= add_c;
                temp_e7 <= eff_b[7];
                temp_a7 <= acc[7];
                temp_op <= req_op;
            end else if (state == PASS2) begin
                state <= IDLE;
            end

            if (commit) begin
                unique case (cur_op)
                    OP_LOAD, OP_INC, OP_DEC: begin
                        acc    <= res;
                        flag_z <= (res == 8'h00);
                        flag_n <= res[7];
                    end
                    OP_CMP: begin
                        flag_c <= carry;
                        flag_z <= (res == 8'h00);
                        flag_n <= res[7];
                    end
                    default: begin
                        acc    <= res;
                        flag_c <= carry;
                        flag_z <= (res == 8'h00);
                        flag_n <= res[7];
                        flag_v <= ovf;
                    end
                endcase
            end
        end
    end
endmodule
